// File: rtl/jtopl_eg_keyseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jtopl_eg_keyseq_pkg
//  Purpose : Shared slot-pipeline constants and slot-to-channel/operator
//            mapping for the envelope and phase stages.
//            A frame has 18 operator slots (9 channels x 2 operators).
//            The slots are grouped in blocks of six: ch0..2 op0, then
//            ch0..2 op1, then the next three channels.
//  Ports   : (package - no ports)
//  Revision: 1.0 - initial release
// ============================================================================
package jtopl_eg_keyseq_pkg;

  localparam int SLOTS = 18;
  localparam int CHANS = 9;

  localparam logic [4:0] LAST_SLOT = 5'd17;
  localparam logic [3:0] CHAN_LIMIT = 4'd9;

  // Channel served by a slot. Out-of-range slots alias to slot 0.
  function automatic logic [3:0] slot_ch(input logic [4:0] slot);
    int s;
    int g;
    int r;
    s = int'(slot);
    if (s >= SLOTS) s = 0;
    g = s / 6;
    r = s % 6;
    return 4'(3 * g + (r % 3));
  endfunction

  // Operator (0 = modulator, 1 = carrier) served by a slot.
  function automatic logic slot_op(input logic [4:0] slot);
    int s;
    s = int'(slot);
    if (s >= SLOTS) s = 0;
    return ((s % 6) >= 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtopl_slot_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : jtopl_slot_cnt
//  Purpose : Slot walker for the time-multiplexed operator pipeline.
//            Produces the slot processed on the current cen step plus its
//            channel and operator.
//  Ports   : clk, rst_n (async, active-low), cen (step enable),
//            zero (frame sync: forces the current slot to 0),
//            cur[4:0] (slot processed this step), ch[3:0], op
//  Revision: 1.0 - initial release
// ============================================================================
module jtopl_slot_cnt
  import jtopl_eg_keyseq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  output logic [4:0] cur,
  output logic [3:0] ch,
  output logic       op
);

  logic [4:0] r_cnt;

  // zero takes priority so a mid-frame sync realigns on this very step.
  // Counter values past the last slot cannot occur, but recover to 0.
  always_comb begin
    cur = 5'd0;
    if (!zero && (r_cnt <= LAST_SLOT)) cur = r_cnt;
    ch = slot_ch(cur);
    op = slot_op(cur);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
    end else if (cen) begin
      r_cnt <= (cur == LAST_SLOT) ? 5'd0 : cur + 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtopl_eg_keyseq.sv
`default_nettype none
// ============================================================================
//  Module  : jtopl_eg_keyseq
//  Purpose : Key-event scheduler. It latches CPU key writes per channel and
//            CSM triggers. It walks the operator slots and emits one key-on
//            or key-off pulse per operator, aligned with that operator's
//            slot.
//  Ports   : clk, rst_n (async, active-low), cen, zero (frame sync),
//            kon_we/kon_ch/kon_val (key register write, cen-independent),
//            csm_trig (CSM key-on for all slots),
//            slot_out/ch_out (slot the outputs refer to),
//            keyon_now/keyoff_now (edge pulses for slot_out)
//  Revision: 1.0 - initial release
// ============================================================================
module jtopl_eg_keyseq
  import jtopl_eg_keyseq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       kon_we,
  input  logic [3:0] kon_ch,
  input  logic       kon_val,
  input  logic       csm_trig,
  output logic [4:0] slot_out,
  output logic [3:0] ch_out,
  output logic       keyon_now,
  output logic       keyoff_now
);

  logic [CHANS-1:0] r_key_req;
  logic [SLOTS-1:0] r_key_last;
  logic [SLOTS-1:0] r_csm_pend;

  logic [4:0] w_cur;
  logic [3:0] w_ch;
  logic       w_op;
  logic       w_k;
  logic       w_l;
  logic       w_p;
  logic       w_keyon;
  logic       w_keyoff;

  jtopl_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .zero  (zero),
    .cur   (w_cur),
    .ch    (w_ch),
    .op    (w_op)
  );

  // Decisions use the register contents before this edge. A key write
  // landing on the same edge as its slot is seen on the next visit.
  // The operator index does not affect keying: both operators of a channel
  // share one key bit, but each operator keeps its own history.
  always_comb begin
    w_k      = r_key_req[w_ch];
    w_l      = r_key_last[w_cur];
    w_p      = r_csm_pend[w_cur] | (w_op & 1'b0);
    // CSM acts as a one-visit key-on. It only fires when the key was idle.
    w_keyon  = ~w_l & (w_k | w_p);
    w_keyoff = ~w_k & w_l & ~w_p;
  end

  // Key register. It is written on any edge and is not gated by cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_req <= '0;
    end else if (kon_we && (kon_ch < CHAN_LIMIT)) begin
      r_key_req[kon_ch] <= kon_val;
    end
  end

  // A trigger on the same edge wins over the clear of the processed slot.
  // The slot then fires again on its next visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csm_pend <= '0;
    end else if (csm_trig) begin
      r_csm_pend <= '1;
    end else if (cen) begin
      r_csm_pend[w_cur] <= 1'b0;
    end
  end

  // Level seen on the slot's last visit. A CSM hit counts as "on" here.
  // If the key is not held, the next visit therefore issues a key-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_last <= '0;
    end else if (cen) begin
      r_key_last[w_cur] <= w_k | w_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_out   <= 5'd0;
      ch_out     <= 4'd0;
      keyon_now  <= 1'b0;
      keyoff_now <= 1'b0;
    end else if (cen) begin
      slot_out   <= w_cur;
      ch_out     <= w_ch;
      keyon_now  <= w_keyon;
      keyoff_now <= w_keyoff;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtopl_eg_keyseq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jtopl_eg_keyseq
//  Purpose : Self-checking bench for jtopl_eg_keyseq. Directed per-cycle
//            vectors with hand-derived expected slot/channel/pulse values.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_jtopl_eg_keyseq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic       kon_we = 1'b0;
  logic [3:0] kon_ch = 4'd0;
  logic       kon_val = 1'b0;
  logic       csm_trig = 1'b0;
  logic [4:0] slot_out;
  logic [3:0] ch_out;
  logic       keyon_now;
  logic       keyoff_now;

  jtopl_eg_keyseq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .zero       (zero),
    .kon_we     (kon_we),
    .kon_ch     (kon_ch),
    .kon_val    (kon_val),
    .csm_trig   (csm_trig),
    .slot_out   (slot_out),
    .ch_out     (ch_out),
    .keyon_now  (keyon_now),
    .keyoff_now (keyoff_now)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cen;
    logic       zero;
    logic       we;
    logic [3:0] wch;
    logic       wval;
    logic       trig;
    logic [4:0] e_slot;
    logic [3:0] e_ch;
    logic       e_on;
    logic       e_off;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int ch_tab [18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};

  localparam logic [17:0] ALL = 18'h3FFFF;
  localparam logic [17:0] M0  = 18'h00001;
  localparam logic [17:0] M3  = 18'h00008;
  localparam logic [17:0] M7  = 18'h00080;
  localparam logic [17:0] M10 = 18'h00400;

  // Output values expected after the most recent queued vector.
  // cen=0 vectors must see these held.
  logic [4:0] l_slot = 5'd0;
  logic [3:0] l_ch = 4'd0;
  logic       l_on = 1'b0;
  logic       l_off = 1'b0;

  function automatic vec_t mk(input logic c, input logic z, input logic w,
                              input logic [3:0] wc, input logic wv, input logic t,
                              input logic [4:0] es, input logic [3:0] ec,
                              input logic eon, input logic eoff);
    vec_t v;
    v.cen = c; v.zero = z; v.we = w; v.wch = wc; v.wval = wv; v.trig = t;
    v.e_slot = es; v.e_ch = ec; v.e_on = eon; v.e_off = eoff;
    return v;
  endfunction

  task automatic add_frame(input logic [17:0] on_m, input logic [17:0] off_m);
    for (int s = 0; s < 18; s++) begin
      vecs.push_back(mk(1'b1, s == 0, 1'b0, 4'd0, 1'b0, 1'b0,
                        5'(s), 4'(ch_tab[s]), on_m[s], off_m[s]));
    end
    l_slot = 5'd17; l_ch = 4'd8; l_on = on_m[17]; l_off = off_m[17];
  endtask

  task automatic add_ctl(input logic w, input logic [3:0] wc, input logic wv, input logic t);
    vecs.push_back(mk(1'b0, 1'b0, w, wc, wv, t, l_slot, l_ch, l_on, l_off));
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cycle(input vec_t v, input string tag);
    cen = v.cen; zero = v.zero; kon_we = v.we; kon_ch = v.wch;
    kon_val = v.wval; csm_trig = v.trig;
    @(posedge clk);
    #1;
    cen = 1'b0; zero = 1'b0; kon_we = 1'b0; csm_trig = 1'b0;
    chk({tag, " slot_out"}, 8'(slot_out), 8'(v.e_slot));
    chk({tag, " ch_out"}, 8'(ch_out), 8'(v.e_ch));
    chk({tag, " keyon_now"}, 8'(keyon_now), 8'(v.e_on));
    chk({tag, " keyoff_now"}, 8'(keyoff_now), 8'(v.e_off));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " slot_out"}, 8'(slot_out), 8'd0);
    chk({tag, " ch_out"}, 8'(ch_out), 8'd0);
    chk({tag, " keyon_now"}, 8'(keyon_now), 8'd0);
    chk({tag, " keyoff_now"}, 8'(keyoff_now), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset, then dirty some state, then reset again mid-frame ----
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    // slot 0: write ch0=1 and trigger CSM on the same edge, so no pulse yet
    cycle(mk(1, 1, 1, 4'd0, 1, 1, 5'd0, 4'd0, 0, 0), "pre0");
    // slot 1: CSM pending, key off -> key-on
    cycle(mk(1, 0, 0, 4'd0, 0, 0, 5'd1, 4'd1, 1, 0), "pre1");
    cycle(mk(1, 0, 0, 4'd0, 0, 0, 5'd2, 4'd2, 1, 0), "pre2");
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- table ----
    add_frame(18'd0, 18'd0);                         // clean map, cleared state
    add_ctl(1, 4'd4, 1, 0);
    add_frame(M7 | M10, 18'd0);
    add_frame(18'd0, 18'd0);
    add_ctl(1, 4'd4, 0, 0);
    add_frame(18'd0, M7 | M10);
    add_ctl(1, 4'd12, 1, 0);                         // ignored channel
    add_frame(18'd0, 18'd0);
    add_frame(18'd0, 18'd0);
    add_ctl(1, 4'd2, 1, 0);                          // on then off between visits
    add_ctl(1, 4'd2, 0, 0);
    add_frame(18'd0, 18'd0);
    add_ctl(0, 4'd0, 0, 1);                          // CSM, all keys off
    add_frame(ALL, 18'd0);
    add_frame(18'd0, ALL);
    add_frame(18'd0, 18'd0);
    add_ctl(1, 4'd0, 1, 1);                          // CSM with ch0 held
    add_frame(ALL, 18'd0);
    add_frame(18'd0, ALL & ~(M0 | M3));
    add_frame(18'd0, 18'd0);
    add_ctl(1, 4'd0, 0, 0);
    add_frame(18'd0, M0 | M3);

    foreach (vecs[i]) cycle(vecs[i], $sformatf("vec%0d", i));

    // ---- cen held low with key writes: outputs frozen ----
    for (int i = 0; i < 5; i++)
      cycle(mk(0, 0, 1, 4'd8, 1, 0, 5'd17, 4'd8, 0, 0), $sformatf("hold%0d", i));
    for (int s = 0; s < 18; s++)
      cycle(mk(1, s == 0, 0, 4'd0, 0, 0, 5'(s), 4'(ch_tab[s]), (s == 14) || (s == 17), 0),
            $sformatf("resume_s%0d", s));

    // ---- mid-frame zero at cnt=9 with ch5 pending ----
    for (int s = 0; s < 9; s++)
      cycle(mk(1, s == 0, 0, 4'd0, 0, 0, 5'(s), 4'(ch_tab[s]), 0, 0), $sformatf("pre_z_s%0d", s));
    cycle(mk(0, 0, 1, 4'd5, 1, 0, 5'd8, 4'd5, 0, 0), "pre_z_write");
    for (int s = 0; s < 18; s++)
      cycle(mk(1, s == 0, 0, 4'd0, 0, 0, 5'(s), 4'(ch_tab[s]), (s == 8) || (s == 11), 0),
            $sformatf("realign_s%0d", s));

    // ---- write on ch4 coinciding with slot 7: slot 7 sees old value ----
    for (int s = 0; s < 18; s++)
      cycle(mk(1, s == 0, s == 7, 4'd4, 1, 0, 5'(s), 4'(ch_tab[s]), s == 10, 0),
            $sformatf("coinc_s%0d", s));
    for (int s = 0; s < 18; s++)
      cycle(mk(1, s == 0, 0, 4'd0, 0, 0, 5'(s), 4'(ch_tab[s]), s == 7, 0),
            $sformatf("coinc2_s%0d", s));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtopl_eg_keyseq.md
Name: jtopl_eg_keyseq

Overview:
Key-event scheduler for the envelope generator's time-multiplexed slot pipeline. It latches CPU key writes per channel and CSM (composite sine mode) triggers, walks the 18 operator slots, and emits exactly one keyon_now or keyoff_now pulse per operator. Each pulse is aligned with that operator's slot, so the envelope state-control stage sees clean edges. It sits between the register interface and the envelope control/PG-reset logic.

Parameters:
SLOTS, 18, operator slots per frame (9 channels x 2 operators)
CHANS, 9, number of channels

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cen  in  1  clock enable; all state advances only when cen=1
zero  in  1  frame sync; when high with cen, the slot processed this step is slot 0
kon_we  in  1  key register write strobe (single cycle, independent of cen)
kon_ch  in  4  channel index for write; values 9..15 are ignored
kon_val  in  1  key bit written (1=on, 0=off)
csm_trig  in  1  CSM key-on trigger pulse (all channels)
slot_out  out  5  slot index the current outputs refer to
ch_out  out  4  channel of slot_out
keyon_now  out  1  key-on edge for slot_out
keyoff_now  out  1  key-off edge for slot_out

Behaviour:
- Reset (rst_n=0, async): key_req[8:0]=0, key_last[17:0]=0, csm_pend[17:0]=0, slot counter=0; slot_out=0, ch_out=0, keyon_now=0, keyoff_now=0.
- Key write: on any clk edge with kon_we=1 and kon_ch<9, key_req[kon_ch]<=kon_val. The write does not depend on cen. It is visible to slot processing from the next edge on.
- CSM: csm_trig=1 sets csm_pend to all ones on that edge. If it coincides with a processed slot, that slot's pend bit is set, not cleared.
- Slot processing on each edge with cen=1:
  - cur = zero ? 0 : cnt.
  - cnt <= (cur==17) ? 0 : cur+1. Values 18..31 are unreachable; if seen, treat as 0.
- Slot map: g=cur/6, r=cur%6, ch=3*g+(r%3), op=r/3. Slots 0..5 map to ch 0,1,2,0,1,2.
- Edge decisions for cur, using pre-edge register values:
  - k = key_req[ch], l = key_last[cur], p = csm_pend[cur].
  - keyon_now <= (k & ~l) | (p & ~k & ~l); keyoff_now <= ~k & l & ~p.
  - key_last[cur] <= k | p. A CSM key-on is therefore followed by a key-off on the next visit if the key is not held.
  - csm_pend[cur] <= 0, unless csm_trig=1 on the same edge.
  - keyon_now and keyoff_now are never both 1.
- Output timing: slot_out<=cur and ch_out<=ch, registered on the same edge. Latency is 1 cen-cycle from slot selection to outputs.
- cen=0: all outputs and state hold. Key writes and csm_trig still latch.
- kon_we on a channel in the same edge as that channel's slot is processed: the processed slot uses the old key_req. The other operator picks up the new value on its visit.
- Rewrite of the same value: produces no event.
- key on then off between two visits of a slot: no event for that slot (level-sampled).
- Mid-frame zero: realigns immediately. Skipped slots keep their key_last and csm_pend and are serviced on their next visit.

Decomposition:
- Shared package holds the SLOTS/CHANS constants and the slot-to-channel/operator mapping function. The envelope and phase stages reuse these.
- One natural sub-module: jtopl_slot_cnt (cen/zero-driven 0..17 counter producing cur, ch, op).

Test Plan:
1. Reset with rst_n=0 mid-frame, release, then 18 cen cycles with zero on cycle 0 -> slot_out runs 0..17 and ch_out runs 0,1,2,0,1,2,3,4,5,3,4,5,6,7,8,6,7,8. No key pulses.
2. Write kon_ch=4, kon_val=1, then run a frame -> keyon_now=1 only at slot_out=7 and slot_out=10. Second frame: no pulses. Write kon_val=0 -> keyoff_now only at slots 7 and 10.
3. Write kon_ch=12 -> key_req unchanged; two frames produce no pulses.
4. Pulse csm_trig with all keys off -> keyon_now on all 18 slots in the next frame, keyoff_now on all 18 the frame after, then silence. Repeat with key_req[0]=1 -> slots 0 and 3 give keyon once and no keyoff.
5. Hold cen=0 for 5 cycles with kon_we pulses -> outputs frozen. The write takes effect at the next visit after cen resumes.
6. Assert zero when cnt=9 -> next slot_out=0, and a pending keyon on slot 11 is delivered in the following frame.
